// File: rtl/debug_ocimem_pkg.sv
// Shared types and jdo field positions for the debug on-chip memory engine.
package debug_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_JRD  = 2'd1,
    ST_CRD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_SETRD = 2'd1,
    OP_RD    = 2'd2,
    OP_WR    = 2'd3
  } op_t;

  localparam int JDO_W          = 38;
  localparam int JDO_RDSET_BIT  = 34;
  localparam int JDO_CLRERR_BIT = 35;

  function automatic logic op_is_read(op_t op);
    return (op == OP_SETRD) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/debug_ocimem_engine_if.sv
// CPU-side Avalon-MM debug slave bus into the on-chip memory engine.
interface debug_ocimem_engine_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    input  cpu_readdata, cpu_waitrequest
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    output cpu_readdata, cpu_waitrequest
  );
endinterface

// File: rtl/debug_ocimem_ram.sv
// Single-port debug RAM: byte-enabled writes, registered read data, contents not reset.
module debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/debug_ocimem_engine.sv
// JTAG/CPU arbiter and sequencer for the shared debug RAM; JTAG always has priority.
// Optional DEBUG_OCIMEM_AUTOINC_EN: MonAReg post-increments after each completed RD/WR.
//
// state | meaning
// IDLE  | issue pending JTAG op, else serve CPU (writes finish here)
// JRD   | JTAG read data on q, captured into MonDReg
// CRD   | CPU read data on q, presented on cpu_readdata
module debug_ocimem_engine
  import debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [JDO_W-1:0]       jdo,
  input  logic                   take_action_ocimem_a,
  input  logic                   take_no_action_ocimem_a,
  input  logic                   take_action_ocimem_b,
  debug_ocimem_engine_if.slave   avl,
  output logic [31:0]            MonDReg,
  output logic                   monitor_ready,
  output logic                   monitor_error
);

  state_t            state;
  op_t               pend_op;
  op_t               new_op;
  logic [ADDR_W-1:0] mon_areg;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] new_addr;
  logic [31:0]       pend_data;
  logic              set_addr;
  logic              strobe_any;
  logic              busy;
  logic              accept;
  logic              drop;
  logic              clr_err;
  logic              cpu_grant;
  logic              inc_now;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[33:32]};

  // Strobe priority a > b > no_action_a; losers vanish without error.
  always_comb begin
    new_op   = OP_NONE;
    new_addr = mon_areg;
    set_addr = 1'b0;
    if (take_action_ocimem_a) begin
      set_addr = 1'b1;
      new_addr = jdo[ADDR_W-1:0];
      if (jdo[JDO_RDSET_BIT]) new_op = OP_SETRD;
    end else if (take_action_ocimem_b) begin
      new_op = OP_WR;
    end else if (take_no_action_ocimem_a) begin
      new_op = OP_RD;
    end
  end

  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign busy       = (pend_op != OP_NONE) || (state == ST_JRD);
  assign accept     = strobe_any && !busy;
  assign drop       = strobe_any && busy;
  assign clr_err    = take_action_ocimem_a && jdo[JDO_CLRERR_BIT];

  // A strobe arriving this cycle already blocks the CPU.
  assign cpu_grant = reset_n && (state == ST_IDLE) && (pend_op == OP_NONE) && !strobe_any;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = pend_addr;
    ram_be    = 4'hF;
    ram_wdata = pend_data;
    if (state == ST_IDLE) begin
      if (pend_op != OP_NONE) begin
        ram_en = 1'b1;
        ram_we = (pend_op == OP_WR);
      end else if (cpu_grant) begin
        ram_addr  = avl.cpu_address;
        ram_be    = avl.cpu_byteenable;
        ram_wdata = avl.cpu_writedata;
        ram_en    = avl.cpu_read | avl.cpu_write;
        ram_we    = avl.cpu_write;
      end
    end
    ram_en = ram_en & reset_n;
    ram_we = ram_we & reset_n;
  end

`ifdef DEBUG_OCIMEM_AUTOINC_EN
  logic jrd_inc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      jrd_inc <= 1'b0;
    end else if (state == ST_IDLE && pend_op != OP_NONE) begin
      jrd_inc <= (pend_op == OP_RD);
    end
  end

  assign inc_now = (state == ST_JRD && jrd_inc) || (state == ST_IDLE && pend_op == OP_WR);
`else
  assign inc_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      pend_op       <= OP_NONE;
      pend_addr     <= '0;
      pend_data     <= '0;
      mon_areg      <= '0;
      MonDReg       <= '0;
      monitor_error <= 1'b0;
    end else begin
      if (accept) begin
        pend_op   <= new_op;
        pend_addr <= new_addr;
        pend_data <= jdo[31:0];
      end else if (state == ST_IDLE) begin
        pend_op <= OP_NONE;
      end

      if (accept && set_addr) mon_areg <= new_addr;
      else if (inc_now)       mon_areg <= mon_areg + ADDR_W'(1);

      monitor_error <= (monitor_error & ~clr_err) | drop;

      unique case (state)
        ST_IDLE: begin
          if (pend_op != OP_NONE) begin
            if (op_is_read(pend_op)) state <= ST_JRD;
          end else if (cpu_grant && avl.cpu_read && !avl.cpu_write) begin
            state <= ST_CRD;
          end
        end
        ST_JRD: begin
          MonDReg <= ram_q;
          state   <= ST_IDLE;
        end
        ST_CRD:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign monitor_ready       = (pend_op == OP_NONE) && (state != ST_JRD);
  assign avl.cpu_waitrequest = !(reset_n && ((state == ST_CRD) || (cpu_grant && avl.cpu_write)));
  assign avl.cpu_readdata    = (state == ST_CRD) ? ram_q : 32'h0;

  debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_debug_ocimem_engine.sv
// Directed bench for debug_ocimem_engine: vector table plus hand-written timing sequences.
module tb_debug_ocimem_engine;
  import debug_ocimem_pkg::*;

`ifdef DEBUG_OCIMEM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        act_a, noact_a, act_b;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  debug_ocimem_engine_if #(.ADDR_W(8)) avl ();

  debug_ocimem_engine #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (act_a),
    .take_no_action_ocimem_a (noact_a),
    .take_action_ocimem_b    (act_b),
    .avl                     (avl),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  typedef enum {K_JWR, K_JRD, K_CWR, K_CRD} kind_t;
  typedef struct {
    kind_t       kind;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  function automatic logic [37:0] mk_jdo(input logic clr, input logic rdset, input logic [31:0] d);
    return {2'b00, clr, rdset, 2'b00, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Set-address strobe; returns one cycle after the strobe.
  task automatic jset(input logic [7:0] addr, input logic rdset, input logic clr);
    jdo   = mk_jdo(clr, rdset, {24'h0, addr});
    act_a = 1'b1;
    tick();
    act_a = 1'b0;
  endtask

  // Write strobe; returns two cycles after the strobe (op complete).
  task automatic jwrite(input logic [31:0] d);
    jdo   = mk_jdo(1'b0, 1'b0, d);
    act_b = 1'b1;
    tick();
    act_b = 1'b0;
    tick();
  endtask

  task automatic cpu_wait(input string name, output logic [31:0] got);
    bit ok = 1'b0;
    got = 32'h0;
    for (int n = 0; n < 8; n++) begin
      sample();
      if (!avl.cpu_waitrequest) begin
        ok  = 1'b1;
        got = avl.cpu_readdata;
        break;
      end
      tick();
    end
    if (!ok) timeout(name);
    tick();
    avl.cpu_read  = 1'b0;
    avl.cpu_write = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] dummy;
    avl.cpu_address    = a;
    avl.cpu_writedata  = d;
    avl.cpu_byteenable = be;
    avl.cpu_write      = 1'b1;
    cpu_wait("cpu_wr_timeout", dummy);
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [31:0] got);
    avl.cpu_address = a;
    avl.cpu_read    = 1'b1;
    cpu_wait("cpu_rd_timeout", got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;

    vec[0]  = '{K_JWR, 8'h01, 32'h1111_1111, 4'hF, 32'h0};
    vec[1]  = '{K_JWR, 8'h02, 32'h2222_2222, 4'hF, 32'h0};
    vec[2]  = '{K_CWR, 8'h03, 32'h3333_3333, 4'hF, 32'h0};
    vec[3]  = '{K_JRD, 8'h03, 32'h0,         4'hF, 32'h3333_3333};
    vec[4]  = '{K_CRD, 8'h01, 32'h0,         4'hF, 32'h1111_1111};
    vec[5]  = '{K_CRD, 8'h02, 32'h0,         4'hF, 32'h2222_2222};
    vec[6]  = '{K_JWR, 8'h40, 32'hAAAA_AAAA, 4'hF, 32'h0};
    vec[7]  = '{K_CWR, 8'h40, 32'h1234_5678, 4'b0011, 32'h0};
    vec[8]  = '{K_JRD, 8'h40, 32'h0,         4'hF, 32'hAAAA_5678};
    vec[9]  = '{K_CWR, 8'h40, 32'hFFFF_FFFF, 4'b1000, 32'h0};
    vec[10] = '{K_CRD, 8'h40, 32'h0,         4'hF, 32'hFFAA_5678};
    vec[11] = '{K_JWR, 8'hFF, 32'hCAFE_F00D, 4'hF, 32'h0};
    vec[12] = '{K_JRD, 8'hFF, 32'h0,         4'hF, 32'hCAFE_F00D};
    vec[13] = '{K_CRD, 8'hFF, 32'h0,         4'hF, 32'hCAFE_F00D};
    vec[14] = '{K_JWR, 8'h00, 32'h0BAD_CAFE, 4'hF, 32'h0};
    vec[15] = '{K_CRD, 8'h00, 32'h0,         4'hF, 32'h0BAD_CAFE};

    reset_n = 1'b0;
    jdo = '0; act_a = 1'b0; noact_a = 1'b0; act_b = 1'b0;
    avl.cpu_address = '0; avl.cpu_read = 1'b0; avl.cpu_write = 1'b0;
    avl.cpu_writedata = '0; avl.cpu_byteenable = '0;
    tick(); tick();
    reset_n = 1'b1;
    sample();
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_ready", {31'h0, monitor_ready}, 32'h1);
    chk("rst_error", {31'h0, monitor_error}, 32'h0);
    chk("rst_readdata", avl.cpu_readdata, 32'h0);
    chk("rst_waitreq", {31'h0, avl.cpu_waitrequest}, 32'h1);
    chk("rst_areg", {24'h0, dut.mon_areg}, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    tick();

    for (int i = 0; i < NV; i++) begin
      case (vec[i].kind)
        K_JWR: begin
          jset(vec[i].addr, 1'b0, 1'b0);
          jwrite(vec[i].data);
        end
        K_CWR: cpu_wr(vec[i].addr, vec[i].data, vec[i].be);
        K_JRD: begin
          jset(vec[i].addr, 1'b1, 1'b0);
          tick(); tick();
          sample();
          chk($sformatf("v%0d_jrd_data", i), MonDReg, vec[i].exp);
          chk($sformatf("v%0d_jrd_ready", i), {31'h0, monitor_ready}, 32'h1);
          chk($sformatf("v%0d_setrd_areg", i), {24'h0, dut.mon_areg}, {24'h0, vec[i].addr});
          tick();
        end
        K_CRD: begin
          cpu_rd(vec[i].addr, got);
          chk($sformatf("v%0d_crd_data", i), got, vec[i].exp);
        end
        default: ;
      endcase
    end

    // Set / write / read-at-address with cycle-exact monitor_ready.
    jset(8'h10, 1'b0, 1'b0);
    sample(); chk("set_only_ready", {31'h0, monitor_ready}, 32'h1);
    tick();
    jdo = mk_jdo(1'b0, 1'b0, 32'hDEAD_BEEF); act_b = 1'b1;
    tick(); act_b = 1'b0;
    sample(); chk("wr_ready_n1", {31'h0, monitor_ready}, 32'h0);
    tick();
    sample(); chk("wr_ready_n2", {31'h0, monitor_ready}, 32'h1);
    chk("wr_areg", {24'h0, dut.mon_areg}, AUTOINC ? 32'h11 : 32'h10);
    tick();
    if (AUTOINC) jset(8'h10, 1'b0, 1'b0);
    noact_a = 1'b1;
    tick(); noact_a = 1'b0;
    sample(); chk("rd_ready_n1", {31'h0, monitor_ready}, 32'h0);
    tick();
    sample(); chk("rd_ready_n2", {31'h0, monitor_ready}, 32'h0);
    tick();
    sample(); chk("rd_ready_n3", {31'h0, monitor_ready}, 32'h1);
    chk("rd_mondreg_n3", MonDReg, 32'hDEAD_BEEF);
    chk("rd_areg", {24'h0, dut.mon_areg}, AUTOINC ? 32'h11 : 32'h10);
    tick();

    // Address wrap at the top of the RAM.
    jset(8'hFF, 1'b0, 1'b0);
    jwrite(32'h0102_0304);
    sample(); chk("wrap_areg", {24'h0, dut.mon_areg}, AUTOINC ? 32'h00 : 32'hFF);
    tick();

    // Back-to-back writes: second is dropped and flags an error.
    jset(8'h30, 1'b0, 1'b0);
    jdo = mk_jdo(1'b0, 1'b0, 32'h1111_2222); act_b = 1'b1;
    tick();
    jdo = mk_jdo(1'b0, 1'b0, 32'h3333_4444);
    tick(); act_b = 1'b0;
    sample();
    chk("drop_error", {31'h0, monitor_error}, 32'h1);
    chk("drop_ready", {31'h0, monitor_ready}, 32'h1);
    tick();
    jset(8'h30, 1'b1, 1'b0);
    tick(); tick();
    sample();
    chk("drop_ram_first", MonDReg, 32'h1111_2222);
    chk("error_sticky", {31'h0, monitor_error}, 32'h1);
    tick();
    jset(8'h00, 1'b0, 1'b1);
    sample(); chk("error_clear", {31'h0, monitor_error}, 32'h0);
    tick();

    // a and b together: b loses silently, no write queued.
    jdo = mk_jdo(1'b0, 1'b0, 32'h0000_0050); act_a = 1'b1; act_b = 1'b1;
    tick(); act_a = 1'b0; act_b = 1'b0;
    sample();
    chk("prio_ready", {31'h0, monitor_ready}, 32'h1);
    chk("prio_error", {31'h0, monitor_error}, 32'h0);
    chk("prio_areg", {24'h0, dut.mon_areg}, 32'h50);
    tick();

    // JTAG write and CPU read to the same word in the same cycle.
    jset(8'h20, 1'b0, 1'b0);
    jdo = mk_jdo(1'b0, 1'b0, 32'h5A5A_0F0F); act_b = 1'b1;
    avl.cpu_address = 8'h20; avl.cpu_read = 1'b1;
    sample(); chk("coll_wait_n0", {31'h0, avl.cpu_waitrequest}, 32'h1);
    tick(); act_b = 1'b0;
    sample(); chk("coll_wait_n1", {31'h0, avl.cpu_waitrequest}, 32'h1);
    tick();
    cpu_wait("coll_timeout", got);
    chk("coll_readdata", got, 32'h5A5A_0F0F);

    // Reset during JRD aborts; a CPU write during reset is discarded.
    jset(8'h01, 1'b1, 1'b0);
    tick();
    sample(); chk("pre_rst_state", 32'(dut.state), 32'(ST_JRD));
    reset_n = 1'b0;
    tick();
    avl.cpu_address = 8'h02; avl.cpu_writedata = 32'h9999_9999;
    avl.cpu_byteenable = 4'hF; avl.cpu_write = 1'b1;
    sample();
    chk("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("mid_rst_ready", {31'h0, monitor_ready}, 32'h1);
    chk("mid_rst_mondreg", MonDReg, 32'h0);
    chk("mid_rst_waitreq", {31'h0, avl.cpu_waitrequest}, 32'h1);
    tick();
    reset_n = 1'b1; avl.cpu_write = 1'b0;
    cpu_rd(8'h02, got);
    chk("rst_write_blocked", got, 32'h2222_2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
